// File: rtl/core_pkg.sv
// core_pkg: shared core widths, register address type and write-back source ids
package core_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef enum logic [1:0] {WB_ALU, WB_LSU, WB_MDU} wb_src_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a rotating priority pointer
module rr_arbiter #(
  parameter int N = 3,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr;
  logic found;
  int best;
  int d;
  // pick the valid requester with the smallest rotational distance from ptr
  always_comb begin
    best = N;
    d = 0;
    found = 1'b0;
    grant_idx = ptr;
    for (int i = 0; i < N; i++) begin
      d = i - int'(ptr) + (i < int'(ptr) ? N : 0);
      if (req[i] && d < best) begin
        best = d;
        found = 1'b1;
        grant_idx = IW'(i);
      end
    end
    grant = found ? N'(1) << grant_idx : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (advance) ptr <= grant_idx == IW'(N - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin write-back arbiter with register busy scoreboard
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][4:0]       req_rd,
  input  logic [NREQ-1:0][XLEN-1:0]  req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rf_write_en,
  output logic [4:0]                 rf_write_add,
  output logic [XLEN-1:0]            rf_write_data,
  input  logic                       rsv_valid,
  input  logic [4:0]                 rsv_rd,
  output logic                       rsv_ready,
  input  logic [4:0]                 rs1_add,
  input  logic [4:0]                 rs2_add,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [31:0]                busy_vec
);
  import core_pkg::*;
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [IW-1:0] gidx;
  logic accept;
  reg_addr_t wb_rd;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req_valid),
    .advance(accept),
    .grant(req_ready),
    .grant_idx(gidx)
  );
  assign accept = |req_ready;
  assign wb_rd = req_rd[gidx];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rf_write_en <= 1'b0;
      rf_write_add <= '0;
      rf_write_data <= '0;
    end else begin
      rf_write_en <= accept && wb_rd != '0;
      if (accept) begin
        rf_write_add <= wb_rd;
        rf_write_data <= req_data[gidx];
      end
    end
  assign rsv_ready = !busy_vec[rsv_rd];
  assign set_mask = (rsv_valid && rsv_ready && rsv_rd != '0) ? NUM_REGS'(1) << rsv_rd : '0;
  assign clr_mask = rf_write_en ? NUM_REGS'(1) << rf_write_add : '0;
  // set is applied after clear so a same-edge reservation survives the commit
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_vec <= '0;
    else busy_vec <= ((busy_vec & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  assign rs1_busy = busy_vec[rs1_add];
  assign rs2_busy = busy_vec[rs2_add];
endmodule
